// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and encodings for the pipeline sequencing controller.
// The FSM state, the PC-source selects and the register-index width live here.
package pipe_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_JMP = 2'b10;
    localparam logic [1:0] PCSEL_EXC = 2'b11;

    function automatic logic load_use_hit(
        input logic             ex_memread,
        input logic [REG_W-1:0] ex_rd,
        input logic [REG_W-1:0] id_rs,
        input logic [REG_W-1:0] id_rt,
        input logic             id_uses_rt
    );
        return ex_memread && (ex_rd != '0) &&
               ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs from the stage registers and the stall/flush/PC controls back to them.
// master = the controller, slave = the datapath.
interface pipe_hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             id_jump;
    logic             ex_memread;
    logic [REG_W-1:0] ex_rd;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ack;
    logic             irq;
    logic             eret;

    logic             pc_we;
    logic             ifid_we;
    logic             idex_we;
    logic             exmem_we;
    logic             ifid_flush;
    logic             idex_flush;
    logic             memwb_bubble;
    logic [1:0]       pc_sel;
    logic             epc_we;
    logic             irq_ack;
    logic             mem_timeout;

    modport master (
        input  id_rs, id_rt, id_uses_rt, id_jump, ex_memread, ex_rd,
               ex_branch_taken, mem_req, mem_ack, irq, eret,
        output pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush,
               memwb_bubble, pc_sel, epc_we, irq_ack, mem_timeout
    );

    modport slave (
        output id_rs, id_rt, id_uses_rt, id_jump, ex_memread, ex_rd,
               ex_branch_taken, mem_req, mem_ack, irq, eret,
        input  pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush,
               memwb_bubble, pc_sel, epc_we, irq_ack, mem_timeout
    );

endinterface

// File: rtl/pipe_wait_timer.sv
// Saturating count of consecutive data-memory wait cycles.
// expired flags that the count has reached MAX.
module pipe_wait_timer #(
    parameter int MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic inc,
    input  logic clr,
    output logic expired
);
    localparam int            W     = $clog2(MAX + 1);
    localparam logic [W-1:0]  LIMIT = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = W'(1);
        end else if (inc && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall, flush and PC-select sequencing for the 5-stage pipeline.
//   state    | meaning
//   RUN      | normal issue; hazards resolved by priority each cycle
//   MEM_WAIT | pipeline frozen awaiting mem_ack, wait timer running
//   ERROR    | memory timeout; pipeline held in bubbles until reset
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    pipe_hazard_ctrl_if.master  bus
);

    state_e state_q, state_d;
    logic   int_en_q, int_en_d;
    logic   tmr_load, tmr_inc, tmr_clr, tmr_expired;
    logic   load_use, stall, take_irq;

    pipe_wait_timer #(.MAX(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (reset),
        .load    (tmr_load),
        .inc     (tmr_inc),
        .clr     (tmr_clr),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d      = state_q;
        int_en_d     = int_en_q;
        tmr_load     = 1'b0;
        tmr_inc      = 1'b0;
        tmr_clr      = 1'b0;
        take_irq     = 1'b0;

        bus.pc_we        = 1'b1;
        bus.ifid_we      = 1'b1;
        bus.idex_we      = 1'b1;
        bus.exmem_we     = 1'b1;
        bus.ifid_flush   = 1'b0;
        bus.idex_flush   = 1'b0;
        bus.memwb_bubble = 1'b0;
        bus.pc_sel       = PCSEL_SEQ;
        bus.epc_we       = 1'b0;
        bus.irq_ack      = 1'b0;
        bus.mem_timeout  = 1'b0;

        load_use = load_use_hit(bus.ex_memread, bus.ex_rd, bus.id_rs,
                                bus.id_rt, bus.id_uses_rt);
        // In MEM_WAIT the request is already outstanding, so only the ack matters.
        stall = !bus.mem_ack &&
                (((state_q == RUN) && bus.mem_req) || (state_q == MEM_WAIT));

        if (state_q == ERROR) begin
            bus.pc_we        = 1'b0;
            bus.ifid_we      = 1'b0;
            bus.idex_we      = 1'b0;
            bus.exmem_we     = 1'b0;
            bus.ifid_flush   = 1'b1;
            bus.idex_flush   = 1'b1;
            bus.memwb_bubble = 1'b1;
            bus.mem_timeout  = 1'b1;
        end else if (stall) begin
            bus.pc_we        = 1'b0;
            bus.ifid_we      = 1'b0;
            bus.idex_we      = 1'b0;
            bus.exmem_we     = 1'b0;
            bus.memwb_bubble = 1'b1;
            if (state_q == RUN) begin
                state_d  = MEM_WAIT;
                tmr_load = 1'b1;
            end else if (tmr_expired) begin
                state_d = ERROR;
            end else begin
                tmr_inc = 1'b1;
            end
        end else begin
            if (state_q == MEM_WAIT) begin
                state_d = RUN;
                tmr_clr = 1'b1;
            end
            if (bus.ex_branch_taken) begin
                bus.pc_sel     = PCSEL_BR;
                bus.ifid_flush = 1'b1;
                bus.idex_flush = 1'b1;
            end else if (load_use) begin
                bus.pc_we      = 1'b0;
                bus.ifid_we    = 1'b0;
                bus.idex_flush = 1'b1;
            end else if (bus.irq && int_en_q) begin
                take_irq       = 1'b1;
                bus.pc_sel     = PCSEL_EXC;
                bus.epc_we     = 1'b1;
                bus.irq_ack    = 1'b1;
                bus.ifid_flush = 1'b1;
                bus.idex_flush = 1'b1;
            end else if (bus.id_jump) begin
                bus.pc_sel     = PCSEL_JMP;
                bus.ifid_flush = 1'b1;
            end
        end

        // Taking the interrupt squashes any eret sitting in ID.
        if (take_irq) begin
            int_en_d = 1'b0;
        end else if (bus.eret && !bus.ex_branch_taken && (state_q != ERROR)) begin
            int_en_d = 1'b1;
        end

        if (!reset) begin
            bus.pc_we        = 1'b0;
            bus.ifid_we      = 1'b0;
            bus.idex_we      = 1'b0;
            bus.exmem_we     = 1'b0;
            bus.ifid_flush   = 1'b1;
            bus.idex_flush   = 1'b1;
            bus.memwb_bubble = 1'b1;
            bus.pc_sel       = PCSEL_SEQ;
            bus.epc_we       = 1'b0;
            bus.irq_ack      = 1'b0;
            bus.mem_timeout  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            int_en_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            int_en_q <= int_en_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios then random traffic,
// expected controls from a cycle-level model of the sequencing rules.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int TO = 3;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       uses_rt;
        logic       jump;
        logic       memread;
        logic       br;
        logic       req;
        logic       ack;
        logic       irq;
        logic       eret;
        logic       rst;
    } stim_t;

    typedef struct packed {
        logic       pc_we;
        logic       ifid_we;
        logic       idex_we;
        logic       exmem_we;
        logic       ifid_flush;
        logic       idex_flush;
        logic       memwb_bubble;
        logic [1:0] pc_sel;
        logic       epc_we;
        logic       irq_ack;
        logic       mem_timeout;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if bus();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   cyc_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;

    // Model: elapsed wait cycles of the outstanding access, sticky timeout, interrupt enable.
    int   m_wait = 0;
    bit   m_dead = 1'b0;
    bit   m_ien  = 1'b1;

    function automatic exp_t idle_exp();
        exp_t e;
        e = '0;
        e.ifid_flush   = 1'b1;
        e.idex_flush   = 1'b1;
        e.memwb_bubble = 1'b1;
        return e;
    endfunction

    task automatic model_step(input stim_t s, output exp_t e);
        bit hit;
        bit taken;
        e = '0;
        e.pc_we = 1'b1; e.ifid_we = 1'b1; e.idex_we = 1'b1; e.exmem_we = 1'b1;
        taken = 1'b0;
        if (!s.rst) begin
            e = idle_exp();
            m_wait = 0; m_dead = 1'b0; m_ien = 1'b1;
            return;
        end
        if (m_dead) begin
            e = idle_exp();
            e.mem_timeout = 1'b1;
            return;
        end
        hit = s.memread && (s.rd != 0) &&
              ((s.rd == s.rs) || (s.uses_rt && (s.rd == s.rt)));
        if (!s.ack && (m_wait > 0 || s.req)) begin
            e.pc_we = 0; e.ifid_we = 0; e.idex_we = 0; e.exmem_we = 0;
            e.memwb_bubble = 1'b1;
            if (m_wait == TO) m_dead = 1'b1;
            else m_wait++;
        end else begin
            m_wait = 0;
            if (s.br) begin
                e.pc_sel = 2'b01; e.ifid_flush = 1; e.idex_flush = 1;
            end else if (hit) begin
                e.pc_we = 0; e.ifid_we = 0; e.idex_flush = 1;
            end else if (s.irq && m_ien) begin
                e.pc_sel = 2'b11; e.epc_we = 1; e.irq_ack = 1;
                e.ifid_flush = 1; e.idex_flush = 1;
                taken = 1'b1;
            end else if (s.jump) begin
                e.pc_sel = 2'b10; e.ifid_flush = 1;
            end
        end
        if (taken) m_ien = 1'b0;
        else if (s.eret && !s.br) m_ien = 1'b1;
    endtask

    task automatic drive(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        reset               = s.rst;
        bus.id_rs           = s.rs;
        bus.id_rt           = s.rt;
        bus.ex_rd           = s.rd;
        bus.id_uses_rt      = s.uses_rt;
        bus.id_jump         = s.jump;
        bus.ex_memread      = s.memread;
        bus.ex_branch_taken = s.br;
        bus.mem_req         = s.req;
        bus.mem_ack         = s.ack;
        bus.irq             = s.irq;
        bus.eret            = s.eret;
        model_step(s, e);
        exp_q.push_back(e);
        cyc_q.push_back(cycle);
        cycle++;
    endtask

    function automatic stim_t quiet();
        stim_t s;
        s = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    // Monitor: the controls are combinational, so one expected word per cycle.
    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        int   c;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            got.pc_we        = bus.pc_we;
            got.ifid_we      = bus.ifid_we;
            got.idex_we      = bus.idex_we;
            got.exmem_we     = bus.exmem_we;
            got.ifid_flush   = bus.ifid_flush;
            got.idex_flush   = bus.idex_flush;
            got.memwb_bubble = bus.memwb_bubble;
            got.pc_sel       = bus.pc_sel;
            got.epc_we       = bus.epc_we;
            got.irq_ack      = bus.irq_ack;
            got.mem_timeout  = bus.mem_timeout;
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL controls cycle=%0d got=%b expected=%b", c, got, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        bus.id_rs = '0; bus.id_rt = '0; bus.ex_rd = '0; bus.id_uses_rt = 0;
        bus.id_jump = 0; bus.ex_memread = 0; bus.ex_branch_taken = 0;
        bus.mem_req = 0; bus.mem_ack = 0; bus.irq = 0; bus.eret = 0;

        s = quiet(); s.rst = 1'b0;
        drive(s); drive(s);
        drive(quiet());

        // load-use on rs, then defaults
        s = quiet(); s.memread = 1; s.rd = 5; s.rs = 5; s.rt = 7; s.uses_rt = 1;
        drive(s); drive(quiet());
        s.rd = 0; s.rs = 0;
        drive(s);
        s = quiet(); s.memread = 1; s.rd = 9; s.rt = 9; s.rs = 2; s.uses_rt = 1;
        drive(s);
        s.uses_rt = 0;
        drive(s);

        // branch beats load-use and irq; irq taken next clean cycle
        s = quiet(); s.br = 1; s.memread = 1; s.rd = 4; s.rs = 4; s.irq = 1;
        drive(s);
        s = quiet(); s.irq = 1;
        drive(s);
        drive(s);
        s = quiet(); s.eret = 1;
        drive(s);
        s = quiet(); s.irq = 1;
        drive(s);
        s = quiet(); s.eret = 1; drive(s);
        s = quiet(); s.jump = 1; drive(s);

        // memory ack on the 4th cycle of the request
        s = quiet(); s.req = 1;
        drive(s); drive(s); drive(s);
        s.ack = 1; drive(s);
        drive(quiet());

        // timeout, sticky, cleared by reset
        s = quiet(); s.req = 1;
        for (int i = 0; i < 7; i++) drive(s);
        s = quiet(); s.rst = 0; drive(s);
        drive(quiet());

        // async reset mid-wait, asserted between edges
        s = quiet(); s.req = 1;
        drive(s); drive(s);
        s.rst = 0; drive(s);
        drive(quiet());

        for (int i = 0; i < 600; i++) begin
            s = quiet();
            s.rs      = 5'($urandom_range(0, 3));
            s.rt      = 5'($urandom_range(0, 3));
            s.rd      = 5'($urandom_range(0, 3));
            s.uses_rt = ($urandom_range(0, 1) != 0);
            s.memread = ($urandom_range(0, 99) < 30);
            s.br      = ($urandom_range(0, 99) < 15);
            s.jump    = ($urandom_range(0, 99) < 15);
            s.irq     = ($urandom_range(0, 99) < 25);
            s.eret    = ($urandom_range(0, 99) < 10);
            if (m_wait > 0) begin
                s.req = 1'b1;
                s.ack = ($urandom_range(0, 99) < 35);
            end else begin
                s.req = ($urandom_range(0, 99) < 25);
                s.ack = ($urandom_range(0, 99) < 30);
            end
            if (m_dead) s.rst = ($urandom_range(0, 3) != 0);
            else        s.rst = ($urandom_range(0, 99) != 0);
            drive(s);
        end

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
